matvec_mem_loader: RTL and testbench
====================================

Name: matvec_mem_loader

Overview:
Upstream stage of the matrix-vector multiplier. On a fill request it reads 9 consecutive 64-bit words from memory: words 0-7 are matrix rows 0-7 and word 8 is the vector. It unpacks each word into 8 bytes and emits one byte per cycle with a one-hot FIFO write select, in the format the multiplier's 9 input FIFOs expect.

Parameters:
ADDR_W, 32, memory address width
ADDR_STRIDE, 1, address increment between consecutive words (1 = word-addressed, 8 = byte-addressed)
NUM_WORDS, 9, words per fill: 8 matrix rows plus 1 vector; fixed by the FIFO count

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
base_addr  input  ADDR_W  address of word 0; sampled when a fill starts
fill  input  1  level request; a fill starts when high in IDLE
clr  input  1  synchronous abort to IDLE
busy  output  1  high in every state except IDLE and DONE
done  output  1  high in DONE
mem_addr  output  ADDR_W  read address
mem_read  output  1  read request; held until accepted
mem_waitrequest  input  1  slave stall; request accepted when mem_read=1 and mem_waitrequest=0
mem_readdata  input  64  read data
mem_readdatavalid  input  1  read data valid; read latency is at least 1 cycle
fifo_en  output  9  one-hot FIFO write enable; [7:0] matrix rows, [8] vector
fifo_data  output  8  byte written to the selected FIFO

Behaviour:
- Reset values (async, rst_n=0): state IDLE; busy, done, mem_read, fifo_en = 0; mem_addr, fifo_data, counters = 0.
- States:
  - IDLE -> REQ when fill=1. Latch base_addr; word_cnt=0.
  - REQ: mem_read=1 and mem_addr = base + word_cnt*ADDR_STRIDE. Go to WAIT when mem_waitrequest=0.
  - WAIT: mem_read=0. When mem_readdatavalid=1, load the 64-bit shift register and go to SHIFT with byte_cnt=0.
  - SHIFT: each cycle drive fifo_en = onehot(word_cnt) and fifo_data = current byte.
    - Byte order is MSB first: bits [63:56] first, [7:0] last.
    - After byte_cnt=7: if word_cnt=8 go to DONE, else word_cnt+1 and go to REQ.
  - DONE: done=1. Return to IDLE only when fill=0, so a consumer holding fill high does not retrigger.
- fifo_en is zero in every state except SHIFT and has exactly one bit set there.
- Latency with zero wait states and read latency 1:
  - first fifo_en 3 cycles after the fill edge in IDLE;
  - 10 cycles per word;
  - done asserted 91 cycles after the fill edge.
- mem_readdatavalid outside WAIT is ignored. This covers data for a read issued before a clr.
- clr has priority over every transition: next state IDLE, outputs zeroed next cycle, no further fifo_en.
- fill dropping mid-operation does not abort; only clr or reset aborts.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values.
- Address arithmetic wraps modulo 2^ADDR_W.

Optional Feature:
MATVEC_LOADER_PREFETCH_EN
- Defined:
  - During SHIFT of word n (n<8), the next read is issued in parallel and its data captured into a 64-bit holding register.
  - At byte 7, if the holding register is valid, the loader goes straight to SHIFT of word n+1. This gives a continuous 72-cycle byte stream once the first word arrives; done 75 cycles after fill with zero wait states and read latency 1.
  - At most one read is outstanding at any time.
  - A stalled prefetch makes SHIFT wait in WAIT as normal.
- Undefined: behaviour exactly as above; no holding register.

Decomposition:
- Package matvec_pkg:
  - loader state enum (IDLE, REQ, WAIT, SHIFT, DONE);
  - NUM_FIFOS=9, BYTES_PER_WORD=8, VEC_FIFO_IDX=8.
- Sub-module mvl_byte_unpacker:
  - 64-bit load/shift register plus a 3-bit byte counter;
  - outputs the current byte and last_byte.
  - The FSM, addressing and prefetch logic stay in matvec_mem_loader.

Test Plan:
- Zero-wait memory, base=0x100, word k = {8{k+1 as byte}} -> 72 writes; FIFO k receives 8 bytes of value k+1; fifo_en=9'h100 for the last 8; mem_addr sequence 0x100..0x108; done at cycle 91.
- Word 0 = 64'h0102030405060708 -> FIFO 0 receives 01,02,...,08 in that order.
- mem_waitrequest held 5 cycles on word 3 -> mem_read and mem_addr stable throughout; byte stream otherwise unchanged; done 5 cycles later.
- clr pulsed during SHIFT of word 4, then mem_readdatavalid for a stale read -> fifo_en=0 from the next cycle; state IDLE; stale data produces no writes.
- fill held high after done -> done stays 1 and no new mem_read; fill low, then high again -> a new 9-word fill starts.
- rst_n asserted during WAIT of word 2 -> outputs at reset values immediately; a later fill restarts from word 0.

Source files
------------

// File: rtl/matvec_pkg.sv
// Shared constants and state encoding for the matrix-vector memory loader.
package matvec_pkg;

   localparam int unsigned NUM_FIFOS      = 9;
   localparam int unsigned BYTES_PER_WORD = 8;
   localparam int unsigned VEC_FIFO_IDX   = 8;
   localparam int unsigned WORD_W         = 64;
   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned STATE_W        = 3;

   typedef logic [STATE_W-1:0] state_t;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_REQ   = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_SHIFT = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/mvl_byte_unpacker.sv
// 64-bit load/shift register emitting one byte per shift, MSB first.
// Shifts in zeros, so the byte output rests at zero once a word is drained.
module mvl_byte_unpacker
   import matvec_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic              load_i,
   input  logic              shift_i,
   input  logic [WORD_W-1:0] data_i,
   output logic [BYTE_W-1:0] byte_o,
   output logic              last_byte_o
);

   localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Clear beats load, load beats shift (a load on the last byte starts the next word).
   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (clear_i) begin
         shreg_d = '0;
         cnt_d   = '0;
      end else if (load_i) begin
         shreg_d = data_i;
         cnt_d   = '0;
      end else if (shift_i) begin
         shreg_d = {shreg_q[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
         cnt_d   = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   assign byte_o      = shreg_q[WORD_W-1 -: BYTE_W];
   assign last_byte_o = (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/matvec_mem_loader.sv
// Reads 8 matrix rows plus a vector word from memory and streams them bytewise
// into the multiplier input FIFOs. MATVEC_LOADER_PREFETCH_EN overlaps the next read with shifting.
module matvec_mem_loader
   import matvec_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned ADDR_STRIDE = 1,
   parameter int unsigned NUM_WORDS   = 9
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic                 fill,
   input  logic                 clr,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic                 mem_read,
   input  logic                 mem_waitrequest,
   input  logic [WORD_W-1:0]    mem_readdata,
   input  logic                 mem_readdatavalid,
   output logic [NUM_FIFOS-1:0] fifo_en,
   output logic [BYTE_W-1:0]    fifo_data
);

   localparam int unsigned WORD_CNT_W = $clog2(VEC_FIFO_IDX + 1);
   localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(NUM_WORDS - 1);

   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0]     base,
                                                   input logic [WORD_CNT_W-1:0] idx);
      return base + ADDR_W'(idx) * ADDR_W'(ADDR_STRIDE);
   endfunction

   state_t                state_q, state_d;
   logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic [ADDR_W-1:0]     base_q, base_d;
   logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
   logic                  mem_read_q, mem_read_d;
   logic [NUM_FIFOS-1:0]  fifo_en_q, fifo_en_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  ub_clear, ub_load, ub_shift, ub_last;
   logic [WORD_W-1:0]     ub_data;
   logic [BYTE_W-1:0]     ub_byte;

`ifdef MATVEC_LOADER_PREFETCH_EN
   logic                  pf_req_q, pf_req_d;
   logic                  pf_wait_q, pf_wait_d;
   logic                  hold_valid_q, hold_valid_d;
   logic [WORD_W-1:0]     hold_q, hold_d;
`endif

   mvl_byte_unpacker u_unpacker (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_i     (ub_clear),
      .load_i      (ub_load),
      .shift_i     (ub_shift),
      .data_i      (ub_data),
      .byte_o      (ub_byte),
      .last_byte_o (ub_last)
   );

   // Next state; registered outputs are derived from the next state so they align with state_q.
   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      base_d     = base_q;
      mem_addr_d = mem_addr_q;
      ub_clear   = 1'b0;
      ub_load    = 1'b0;
      ub_shift   = 1'b0;
      ub_data    = mem_readdata;
`ifdef MATVEC_LOADER_PREFETCH_EN
      pf_req_d     = pf_req_q;
      pf_wait_d    = pf_wait_q;
      hold_valid_d = hold_valid_q;
      hold_d       = hold_q;
      if (pf_req_q && !mem_waitrequest) begin
         pf_req_d  = 1'b0;
         pf_wait_d = 1'b1;
      end
      if (pf_wait_q && mem_readdatavalid) begin
         pf_wait_d    = 1'b0;
         hold_valid_d = 1'b1;
         hold_d       = mem_readdata;
      end
`endif

      case (state_q)
         ST_IDLE: begin
            if (fill) begin
               state_d    = ST_REQ;
               base_d     = base_addr;
               word_cnt_d = '0;
               mem_addr_d = base_addr;
            end
         end
         ST_REQ: begin
            if (!mem_waitrequest) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_readdatavalid) begin
               ub_load = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            ub_shift = 1'b1;
            if (ub_last) begin
               if (word_cnt_q == LAST_WORD) begin
                  state_d = ST_DONE;
               end else begin
                  word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
`ifdef MATVEC_LOADER_PREFETCH_EN
                  pf_req_d     = 1'b0;
                  pf_wait_d    = 1'b0;
                  hold_valid_d = 1'b0;
                  if (hold_valid_q) begin
                     ub_load = 1'b1;
                     ub_data = hold_q;
                  end else if (pf_wait_q && mem_readdatavalid) begin
                     ub_load = 1'b1;
                  end else if (pf_wait_q || (pf_req_q && !mem_waitrequest)) begin
                     state_d = ST_WAIT;
                  end else begin
                     // prefetch still stalled: REQ keeps the same request up
                     state_d = ST_REQ;
                  end
`else
                  state_d    = ST_REQ;
                  mem_addr_d = word_addr(base_q, word_cnt_d);
`endif
               end
            end
         end
         ST_DONE: begin
            if (!fill) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

`ifdef MATVEC_LOADER_PREFETCH_EN
      // Every word load (except the vector) launches the read of the following word.
      if (ub_load && (word_cnt_d != LAST_WORD)) begin
         pf_req_d   = 1'b1;
         mem_addr_d = word_addr(base_q, word_cnt_d + WORD_CNT_W'(1));
      end
`endif

      if (clr) begin
         state_d    = ST_IDLE;
         word_cnt_d = '0;
         mem_addr_d = '0;
         ub_clear   = 1'b1;
         ub_load    = 1'b0;
         ub_shift   = 1'b0;
`ifdef MATVEC_LOADER_PREFETCH_EN
         pf_req_d     = 1'b0;
         pf_wait_d    = 1'b0;
         hold_valid_d = 1'b0;
`endif
      end

      mem_read_d = (state_d == ST_REQ);
`ifdef MATVEC_LOADER_PREFETCH_EN
      mem_read_d = mem_read_d | pf_req_d;
`endif
      busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_d    = (state_d == ST_DONE);
      fifo_en_d = (state_d == ST_SHIFT) ? (NUM_FIFOS'(1) << word_cnt_d) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         word_cnt_q <= '0;
         base_q     <= '0;
         mem_addr_q <= '0;
         mem_read_q <= 1'b0;
         fifo_en_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         base_q     <= base_d;
         mem_addr_q <= mem_addr_d;
         mem_read_q <= mem_read_d;
         fifo_en_q  <= fifo_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

`ifdef MATVEC_LOADER_PREFETCH_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pf_req_q     <= 1'b0;
         pf_wait_q    <= 1'b0;
         hold_valid_q <= 1'b0;
         hold_q       <= '0;
      end else begin
         pf_req_q     <= pf_req_d;
         pf_wait_q    <= pf_wait_d;
         hold_valid_q <= hold_valid_d;
         hold_q       <= hold_d;
      end
   end
`endif

   assign busy      = busy_q;
   assign done      = done_q;
   assign mem_addr  = mem_addr_q;
   assign mem_read  = mem_read_q;
   assign fifo_en   = fifo_en_q;
   assign fifo_data = ub_byte;

endmodule

// File: tb/tb_matvec_mem_loader.sv
// Directed bench for matvec_mem_loader: bytewise stream, latency, stall, clr, done hold and reset.
`timescale 1ns/1ps
module tb_matvec_mem_loader;

`ifdef MATVEC_LOADER_PREFETCH_EN
   localparam int DONE_LAT    = 75;
   localparam int STALL_EXTRA = 0;
`else
   localparam int DONE_LAT    = 91;
   localparam int STALL_EXTRA = 5;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] base_addr = '0;
   logic        fill = 1'b0;
   logic        clr = 1'b0;
   logic        busy, done, mem_read;
   logic [31:0] mem_addr;
   logic        mem_waitrequest = 1'b0;
   logic [63:0] mem_readdata = '0;
   logic        mem_readdatavalid = 1'b0;
   logic [8:0]  fifo_en;
   logic [7:0]  fifo_data;

   matvec_mem_loader #(.ADDR_W(32), .ADDR_STRIDE(1), .NUM_WORDS(9)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .base_addr         (base_addr),
      .fill              (fill),
      .clr               (clr),
      .busy              (busy),
      .done              (done),
      .mem_addr          (mem_addr),
      .mem_read          (mem_read),
      .mem_waitrequest   (mem_waitrequest),
      .mem_readdata      (mem_readdata),
      .mem_readdatavalid (mem_readdatavalid),
      .fifo_en           (fifo_en),
      .fifo_data         (fifo_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_vec = 0;
   int          n_err = 0;
   int          pat = 0;
   logic [31:0] cur_base = '0;
   logic        stall_en = 1'b0;
   logic [31:0] stall_addr = '0;
   logic        inject_stale = 1'b0;

   // Memory-side state (written only by the memory model)
   int          stall_cnt = 0;
   int          stall_viol = 0;
   logic        wait_prev = 1'b0;
   logic        acc_q = 1'b0;
   logic [31:0] acc_addr = '0;
   logic [31:0] addr_log[$];

   // Monitor state (written only by the monitor)
   logic [8:0]  wr_en[$];
   logic [7:0]  wr_data[$];
   int          wr_cyc[$];
   int          onehot_viol = 0;
   int          rd_cycles = 0;

   function automatic logic [7:0] byte_of(int p, int k, int j);
      if (p == 1 && k == 0) return 8'(j + 1);
      return 8'(k + 1);
   endfunction

   function automatic logic [63:0] mem_word(logic [31:0] idx);
      logic [63:0] w;
      w = '0;
      for (int j = 0; j < 8; j++) w[63 - 8*j -: 8] = byte_of(pat, int'(idx), j);
      return w;
   endfunction

   // Memory: one read in flight, data one cycle after acceptance, optional 5-cycle stall.
   always @(negedge clk) begin
      mem_readdatavalid = 1'b0;
      if (acc_q) begin
         mem_readdatavalid = 1'b1;
         mem_readdata      = mem_word(acc_addr - cur_base);
      end else if (inject_stale) begin
         mem_readdatavalid = 1'b1;
         mem_readdata      = 64'hDEAD_BEEF_0BAD_F00D;
      end
      if (wait_prev && !(mem_read === 1'b1 && mem_addr === stall_addr)) stall_viol++;
      if (!stall_en) stall_cnt = 0;
      mem_waitrequest = stall_en && (mem_read === 1'b1) && (mem_addr === stall_addr) && (stall_cnt < 5);
      if (mem_waitrequest) stall_cnt++;
      wait_prev = mem_waitrequest;
      acc_q     = (mem_read === 1'b1) && !mem_waitrequest;
      acc_addr  = mem_addr;
      if (acc_q) addr_log.push_back(mem_addr);
   end

   always @(negedge clk) begin
      if (fifo_en !== 9'h000) begin
         wr_en.push_back(fifo_en);
         wr_data.push_back(fifo_data);
         wr_cyc.push_back(cyc);
         if (!$onehot(fifo_en)) onehot_viol++;
      end
      if (mem_read === 1'b1) rd_cycles++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   int c0, w0, a0;

   task automatic start_fill(input logic [31:0] base);
      @(negedge clk);
      cur_base  = base;
      base_addr = base;
      fill      = 1'b1;
      c0        = cyc;
      w0        = wr_en.size();
      a0        = addr_log.size();
   endtask

   task automatic wait_done(input string tag, input int exp_lat);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_seen"}, 64'(done), 64'(1));
      check({tag, "_done_lat"}, 64'(cyc - c0), 64'(exp_lat));
   endtask

   task automatic check_stream(input string tag, input int p);
      check({tag, "_nwrites"}, 64'(wr_en.size() - w0), 64'(72));
      for (int i = 0; i < 72 && (w0 + i) < wr_en.size(); i++) begin
         check($sformatf("%s_en%0d", tag, i), 64'(wr_en[w0 + i]), 64'(9'(1) << (i / 8)));
         check($sformatf("%s_data%0d", tag, i), 64'(wr_data[w0 + i]), 64'(byte_of(p, i / 8, i % 8)));
      end
   endtask

   task automatic check_addrs(input string tag, input logic [31:0] base);
      check({tag, "_nreads"}, 64'(addr_log.size() - a0), 64'(9));
      for (int k = 0; k < 9 && (a0 + k) < addr_log.size(); k++)
         check($sformatf("%s_addr%0d", tag, k), 64'(addr_log[a0 + k]), 64'(base + 32'(k)));
   endtask

   initial begin
      int wcnt, acnt, rcnt, n;
      logic [7:0] exp_b;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_mem_read", 64'(mem_read), 64'(0));
      check("rst_mem_addr", 64'(mem_addr), 64'(0));
      check("rst_fifo_en", 64'(fifo_en), 64'(0));
      check("rst_fifo_data", 64'(fifo_data), 64'(0));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Zero-wait fill, word k = {8{k+1}}
      pat = 0;
      start_fill(32'h100);
      @(negedge clk);
      check("t1_busy", 64'(busy), 64'(1));
      wait_done("t1", DONE_LAT);
      check("t1_first_en_lat", 64'(wr_cyc[w0] - c0), 64'(3));
      check_stream("t1", 0);
      check_addrs("t1", 32'h100);
      check("t1_onehot", 64'(onehot_viol), 64'(0));

      // fill held high after done: no retrigger
      acnt = addr_log.size();
      rcnt = rd_cycles;
      repeat (10) @(negedge clk);
      check("hold_done", 64'(done), 64'(1));
      check("hold_busy", 64'(busy), 64'(0));
      check("hold_no_reads", 64'(addr_log.size() - acnt), 64'(0));
      check("hold_no_mem_read", 64'(rd_cycles - rcnt), 64'(0));
      fill = 1'b0;
      @(negedge clk);
      check("idle_done", 64'(done), 64'(0));
      @(negedge clk);

      // Second fill, word 0 = 64'h0102030405060708
      pat = 1;
      start_fill(32'h200);
      wait_done("t2", DONE_LAT);
      for (int j = 0; j < 8; j++) begin
         exp_b = 8'(j + 1);
         check($sformatf("t2_row0_en%0d", j), 64'(wr_en[w0 + j]), 64'(9'h001));
         check($sformatf("t2_row0_b%0d", j), 64'(wr_data[w0 + j]), 64'(exp_b));
      end
      check_stream("t2", 1);
      fill = 1'b0;
      repeat (2) @(negedge clk);

      // 5-cycle waitrequest on word 3
      pat        = 0;
      stall_addr = 32'h303;
      stall_en   = 1'b1;
      n          = stall_viol;
      start_fill(32'h300);
      wait_done("t3", DONE_LAT + STALL_EXTRA);
      check("t3_stall_cycles", 64'(stall_cnt), 64'(5));
      check("t3_stall_stable", 64'(stall_viol - n), 64'(0));
      check_stream("t3", 0);
      check_addrs("t3", 32'h300);
      stall_en = 1'b0;
      fill     = 1'b0;
      repeat (2) @(negedge clk);

      // clr during SHIFT of word 4 (fill dropped early must not abort), then stale data
      start_fill(32'h400);
      @(negedge clk);
      fill = 1'b0;
      n = 0;
      while (fifo_en !== 9'h010 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t4_reached_word4", 64'(fifo_en), 64'(9'h010));
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("t4_clr_fifo_en", 64'(fifo_en), 64'(0));
      check("t4_clr_fifo_data", 64'(fifo_data), 64'(0));
      check("t4_clr_busy", 64'(busy), 64'(0));
      check("t4_clr_mem_read", 64'(mem_read), 64'(0));
      check("t4_clr_mem_addr", 64'(mem_addr), 64'(0));
      wcnt = wr_en.size();
      acnt = addr_log.size();
      @(posedge clk);
      #1 inject_stale = 1'b1;
      @(posedge clk);
      #1 inject_stale = 1'b0;
      repeat (4) @(negedge clk);
      check("t4_stale_no_writes", 64'(wr_en.size() - wcnt), 64'(0));
      check("t4_stale_idle", 64'(busy), 64'(0));
      check("t4_stale_no_reads", 64'(addr_log.size() - acnt), 64'(0));

      // Async reset during WAIT of word 2, then a fresh fill
      start_fill(32'h500);
      n = 0;
      while (addr_log.size() < a0 + 3 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("t5_reached_word2", 64'(addr_log.size() - a0), 64'(3));
      rst_n = 1'b0;
      #1;
      check("t5_rst_busy", 64'(busy), 64'(0));
      check("t5_rst_done", 64'(done), 64'(0));
      check("t5_rst_mem_read", 64'(mem_read), 64'(0));
      check("t5_rst_mem_addr", 64'(mem_addr), 64'(0));
      check("t5_rst_fifo_en", 64'(fifo_en), 64'(0));
      check("t5_rst_fifo_data", 64'(fifo_data), 64'(0));
      @(negedge clk);
      fill = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      start_fill(32'h600);
      wait_done("t6", DONE_LAT);
      check_stream("t6", 0);
      check_addrs("t6", 32'h600);
      check("final_onehot", 64'(onehot_viol), 64'(0));
      fill = 1'b0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
